// File: rtl/lif_neuron_if.sv
// Bus between the MAC stage / readout and one LIF output neuron.
// The neuron sits on the slave side and the MAC stage/readout on the master side.
interface lif_neuron_if #(
  parameter int unsigned VMEM_WIDTH = 24,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned SUM_WIDTH  = 21
);
  logic                  start;
  logic [SUM_WIDTH-1:0]  sum_in;
  logic                  sum_valid;
  logic                  spike;
  logic [CNT_WIDTH-1:0]  spike_count;
  logic [VMEM_WIDTH-1:0] v_mem;
  logic                  busy;
  logic                  done;

  modport master (
    output start, sum_in, sum_valid,
    input  spike, spike_count, v_mem, busy, done
  );

  modport slave (
    input  start, sum_in, sum_valid,
    output spike, spike_count, v_mem, busy, done
  );
endinterface

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire output neuron: saturating membrane with shift leak,
// refractory blanking and a per-window spike counter used as classification score.
module lif_neuron #(
  parameter int unsigned VMEM_WIDTH = 24,
  parameter int unsigned THRESHOLD  = 1000,
  parameter int unsigned LEAK_SHIFT = 4,
  parameter int unsigned REFRACT    = 2,
  parameter int unsigned NUM_STEPS  = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input logic        clk,
  input logic        rst_n,
  lif_neuron_if.slave nrn
);
  localparam int unsigned STEP_WIDTH = 8;
  localparam int unsigned REFR_WIDTH = 4;
  localparam int unsigned EXT_WIDTH  = VMEM_WIDTH + 1;

  localparam logic [VMEM_WIDTH-1:0] VMAX      = '1;
  localparam logic [VMEM_WIDTH-1:0] THR       = VMEM_WIDTH'(THRESHOLD);
  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(NUM_STEPS - 1);
  localparam logic [REFR_WIDTH-1:0] REFR_INIT = REFR_WIDTH'(REFRACT);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state_q;
  logic [VMEM_WIDTH-1:0]   v_mem_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [STEP_WIDTH-1:0]   step_q;
  logic [REFR_WIDTH-1:0]   refr_q;
  logic                    spike_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    accept_c;
  logic                    fire_c;
  logic [VMEM_WIDTH-1:0]   leaked_c;
  logic [EXT_WIDTH-1:0]    v_sum_c;
  logic [VMEM_WIDTH-1:0]   v_sat_c;

  // Next membrane value: leak, add (blanked) input at one extra bit, then clamp.
  always_comb begin
    accept_c = 1'b0;
    fire_c   = 1'b0;
    leaked_c = v_mem_q - (v_mem_q >> LEAK_SHIFT);
    v_sum_c  = EXT_WIDTH'(leaked_c);
    if (refr_q == '0) begin
      v_sum_c = EXT_WIDTH'(leaked_c) + EXT_WIDTH'(nrn.sum_in);
    end
    v_sat_c  = v_sum_c[VMEM_WIDTH] ? VMAX : v_sum_c[VMEM_WIDTH-1:0];
    accept_c = (state_q == RUN) && nrn.sum_valid && !nrn.start;
    fire_c   = (refr_q == '0) && (v_sat_c >= THR);
  end

  // State machine and registered outputs; start always wins over a sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_mem_q <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      refr_q  <= '0;
      spike_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      spike_q <= 1'b0;
      if (nrn.start) begin
        state_q <= RUN;
        v_mem_q <= '0;
        cnt_q   <= '0;
        step_q  <= '0;
        refr_q  <= '0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else if (accept_c) begin
        if (fire_c) begin
          spike_q <= 1'b1;
          v_mem_q <= '0;
          refr_q  <= REFR_INIT;
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end else begin
          v_mem_q <= v_sat_c;
          if (refr_q != '0) begin
            refr_q <= refr_q - REFR_WIDTH'(1);
          end
        end
        step_q <= step_q + STEP_WIDTH'(1);
        if (step_q == LAST_STEP) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign nrn.spike       = spike_q;
  assign nrn.spike_count = cnt_q;
  assign nrn.v_mem       = v_mem_q;
  assign nrn.busy        = busy_q;
  assign nrn.done        = done_q;
endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: default-threshold and max-threshold instances driven in
// lockstep, checked every cycle against an arithmetic model plus directed values.
module tb_lif_neuron;
  localparam int unsigned VW   = 24;
  localparam int unsigned CW   = 8;
  localparam int unsigned NS   = 16;
  localparam int unsigned RF   = 2;
  localparam int unsigned LS   = 4;
  localparam int unsigned THR0 = 1000;
  localparam int unsigned THR1 = (1 << 24) - 1;
  localparam longint      VMAXL = (longint'(1) << VW) - 1;
  localparam longint      CMAXL = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lif_neuron_if #(.VMEM_WIDTH(VW), .CNT_WIDTH(CW)) bus0 ();
  lif_neuron_if #(.VMEM_WIDTH(VW), .CNT_WIDTH(CW)) bus1 ();

  lif_neuron #(.VMEM_WIDTH(VW), .THRESHOLD(THR0), .LEAK_SHIFT(LS), .REFRACT(RF),
               .NUM_STEPS(NS), .CNT_WIDTH(CW))
    u_dut0 (.clk(clk), .rst_n(rst_n), .nrn(bus0.slave));

  lif_neuron #(.VMEM_WIDTH(VW), .THRESHOLD(THR1), .LEAK_SHIFT(LS), .REFRACT(RF),
               .NUM_STEPS(NS), .CNT_WIDTH(CW))
    u_dut1 (.clk(clk), .rst_n(rst_n), .nrn(bus1.slave));

  int n_chk = 0;
  int n_fail = 0;

  longint m_vm[2];
  longint m_thr[2];
  int     m_refr[2];
  int     m_cnt[2];
  int     m_step[2];
  bit     m_run[2];
  bit     m_spk[2];
  bit     m_busy[2];
  bit     m_done[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural neuron: plain integer arithmetic on the window rules.
  function automatic void model_step(input int k, input bit r, input bit st, input bit sv,
                                     input longint s);
    longint v;
    m_spk[k] = 1'b0;
    if (!r) begin
      m_vm[k] = 0; m_cnt[k] = 0; m_step[k] = 0; m_refr[k] = 0;
      m_run[k] = 0; m_busy[k] = 0; m_done[k] = 0;
    end else if (st) begin
      m_vm[k] = 0; m_cnt[k] = 0; m_step[k] = 0; m_refr[k] = 0;
      m_run[k] = 1; m_busy[k] = 1; m_done[k] = 0;
    end else if (m_run[k] && sv) begin
      v = m_vm[k] - m_vm[k] / (longint'(1) << LS);
      if (m_refr[k] == 0) v = v + s;
      if (v > VMAXL) v = VMAXL;
      if (m_refr[k] == 0 && v >= m_thr[k]) begin
        m_spk[k] = 1'b1;
        m_vm[k] = 0;
        m_refr[k] = RF;
        if (m_cnt[k] < CMAXL) m_cnt[k]++;
      end else begin
        m_vm[k] = v;
        if (m_refr[k] > 0) m_refr[k]--;
      end
      m_step[k]++;
      if (m_step[k] == NS) begin
        m_run[k] = 0; m_busy[k] = 0; m_done[k] = 1;
      end
    end
  endfunction

  task automatic drive(input bit r, input bit st, input bit sv, input int unsigned s);
    rst_n = r;
    bus0.start = st;     bus1.start = st;
    bus0.sum_valid = sv; bus1.sum_valid = sv;
    bus0.sum_in = 21'(s); bus1.sum_in = 21'(s);
    @(posedge clk);
    model_step(0, r, st, sv, longint'(21'(s)));
    model_step(1, r, st, sv, longint'(21'(s)));
    #1;
    chk("n0.spike", 32'(bus0.spike), 32'(m_spk[0]));
    chk("n0.v_mem", 32'(bus0.v_mem), 32'(m_vm[0]));
    chk("n0.count", 32'(bus0.spike_count), 32'(m_cnt[0]));
    chk("n0.busy",  32'(bus0.busy), 32'(m_busy[0]));
    chk("n0.done",  32'(bus0.done), 32'(m_done[0]));
    chk("n1.spike", 32'(bus1.spike), 32'(m_spk[1]));
    chk("n1.v_mem", 32'(bus1.v_mem), 32'(m_vm[1]));
    chk("n1.count", 32'(bus1.spike_count), 32'(m_cnt[1]));
    chk("n1.busy",  32'(bus1.busy), 32'(m_busy[1]));
    chk("n1.done",  32'(bus1.done), 32'(m_done[1]));
  endtask

  initial begin
    int n;
    bit sv;
    bit st;
    bit r;
    int unsigned s;
    m_thr[0] = THR0;
    m_thr[1] = THR1;
    for (int k = 0; k < 2; k++) model_step(k, 1'b0, 1'b0, 1'b0, 0);

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 500);
    chk("rst.v_mem", 32'(bus0.v_mem), 32'd0);
    chk("rst.busy", 32'(bus0.busy), 32'd0);

    // Constant 400 input: fires at steps 3, 8 and 13
    drive(1'b1, 1'b1, 1'b0, 0);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, 400);
      if (i == 1) chk("c400.step1", 32'(bus0.v_mem), 32'd400);
      if (i == 2) chk("c400.step2", 32'(bus0.v_mem), 32'd775);
      if (i == 3) chk("c400.fire3", 32'({bus0.spike, bus0.v_mem}), 32'({1'b1, 24'd0}));
      if (i == 8 || i == 13) chk("c400.fire", 32'(bus0.spike), 32'd1);
      if (i == 4 || i == 5) chk("c400.blank", 32'(bus0.v_mem), 32'd0);
    end
    chk("c400.done", 32'(bus0.done), 32'd1);
    chk("c400.count", 32'(bus0.spike_count), 32'd3);
    drive(1'b1, 1'b0, 1'b1, 400);
    chk("c400.hold", 32'(bus0.spike_count), 32'd3);

    // Leak-only decay
    drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b1, 800);
    chk("leak.0", 32'(bus0.v_mem), 32'd800);
    drive(1'b1, 1'b0, 1'b1, 0);
    chk("leak.1", 32'(bus0.v_mem), 32'd750);
    drive(1'b1, 1'b0, 1'b1, 0);
    chk("leak.2", 32'(bus0.v_mem), 32'd704);
    drive(1'b1, 1'b0, 1'b1, 0);
    chk("leak.3", 32'({bus0.spike, bus0.v_mem}), 32'({1'b0, 24'd660}));

    // Saturation toward the max threshold instance
    drive(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b1, 2097151);
    chk("sat.fired", 32'(bus1.spike_count > 0), 32'd1);

    // Gaps, then restart at step 7
    drive(1'b1, 1'b1, 1'b0, 0);
    n = 0;
    while (n < 7) begin
      sv = 1'($urandom_range(0, 1));
      drive(1'b1, 1'b0, sv, $urandom_range(0, 900));
      if (sv) n++;
    end
    drive(1'b1, 1'b1, 1'b0, 0);
    chk("restart.v_mem", 32'(bus0.v_mem), 32'd0);
    chk("restart.busy", 32'(bus0.busy), 32'd1);
    n = 0;
    while (n < 16) begin
      sv = 1'($urandom_range(0, 1));
      drive(1'b1, 1'b0, sv, $urandom_range(0, 900));
      if (sv) n++;
      if (n == 15 && sv) chk("restart.not_done", 32'(bus0.done), 32'd0);
    end
    chk("restart.done", 32'(bus0.done), 32'd1);

    // Reset mid-window, then samples ignored until start
    drive(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 300);
    drive(1'b0, 1'b0, 1'b1, 300);
    chk("mrst.all", 32'({bus0.spike, bus0.spike_count, bus0.v_mem, bus0.busy, bus0.done}), 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 900);
    chk("mrst.ignored", 32'(bus0.v_mem), 32'd0);

    // Collision: start with a valid sample drops the sample
    drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b1, 600);
    drive(1'b1, 1'b1, 1'b1, 2000);
    chk("coll.spike", 32'(bus0.spike), 32'd0);
    chk("coll.v_mem", 32'(bus0.v_mem), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 39) == 0);
      sv = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2097151) : $urandom_range(0, 700);
      drive(r, st, sv, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire output neuron that directly consumes the registered 21-bit weighted-spike sum from the 25-input MAC stage, one sum per timestep. It integrates the sums into a saturating membrane potential with shift-based leak and fires on threshold crossing. After each fire it applies a refractory period and counts output spikes over a fixed window of timesteps per input image. The spike count is the classification score the readout compares across neurons.

## Interface
- VMEM_WIDTH, 24: membrane potential width, unsigned.
- THRESHOLD, 1000: fire when potential ≥ THRESHOLD. Legal range 1..2^VMEM_WIDTH-1.
- LEAK_SHIFT, 4: per-step leak = v_mem >> LEAK_SHIFT. Legal range 1..VMEM_WIDTH-1.
- REFRACT, 2: timesteps of input blanking after a spike. Legal range 0..15.
- NUM_STEPS, 16: timesteps per image window. Legal range 1..255.
- CNT_WIDTH, 8: spike counter width.
- clk, input, 1: clock. All state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: single-cycle pulse. Clears state and opens a new window.
- sum_in, input, 21: unsigned synaptic sum from the MAC stage (MAC sumOut).
- sum_valid, input, 1: sum_in holds one timestep's input this cycle.
- spike, output, 1: one-cycle fire pulse.
- spike_count, output, CNT_WIDTH: spikes fired in the current or last window.
- v_mem, output, VMEM_WIDTH: membrane potential (debug/observability).
- busy, output, 1: window in progress.
- done, output, 1: window complete. Held until the next start.

## Operation
- Reset value of every output and internal register is 0; the state machine goes to IDLE.
- States:
  - IDLE → RUN on start.
  - RUN → DONE when the NUM_STEPS-th valid sample is accepted.
  - DONE → RUN on start.
  - start in RUN restarts the window: same clear as from IDLE.
- On start: v_mem, spike_count, the step counter and the refractory counter are cleared; spike=0, done=0, busy=1.
- A sample is accepted only in RUN with sum_valid=1 and start=0. Otherwise the potential and counters hold.
- Per accepted sample:
  - leaked = v_mem − (v_mem >> LEAK_SHIFT).
  - in = (refr_cnt ≠ 0) ? 0 : sum_in.
  - v_next = leaked + in, computed at VMEM_WIDTH+1 bits and saturated to 2^VMEM_WIDTH−1. It never wraps.
  - If refr_cnt = 0 and v_next ≥ THRESHOLD: spike=1, v_mem ← 0, refr_cnt ← REFRACT, spike_count += 1. The count saturates at all-ones.
  - Otherwise: v_mem ← v_next, and refr_cnt decrements if nonzero.
  - The step counter increments.
- A refractory step applies leak only. No spike is possible during it.
- sum_valid outside RUN is ignored.
- start together with sum_valid: start wins and that sample is dropped.
- DONE: busy=0, done=1. spike_count and v_mem hold for readout.

## Timing
- Latency: spike, v_mem and spike_count reflect a sample on the edge that accepts it, i.e. they are visible the cycle after sum_valid.
- spike is high for exactly one cycle per firing sample and is low in every other cycle.
- Back-to-back sum_valid every cycle is supported at full throughput.
- Gaps with sum_valid=0 are allowed and do not count as timesteps.
- The edge accepting the NUM_STEPS-th sample sets done=1 and busy=0. spike for that sample is asserted in the same cycle.
- start is honored on the edge it is sampled: busy=1 and done=0 from the next cycle.
- rst_n=0 on any edge, including mid-window, forces all outputs to 0 from the next cycle, regardless of start and sum_valid.

## Test plan
- Defaults; start; 16 consecutive samples with sum_in=400 → v_mem 400, 775, then spike at step 3 (1127 ≥ 1000, v_mem=0); steps 4–5 blanked; spikes again at steps 8 and 13; done=1 with spike_count=3.
- Leak: start; one sample of 800, then zeros → v_mem 800, 750, 704, 660; spike never asserted.
- Saturation: THRESHOLD=2^24−1; sum_in=2097151 every step → v_mem climbs monotonically, clamps at 16777215 and fires that step; v_mem never holds a value less than its previous value except the reset to 0 on fire.
- Gaps and restart: interleave sum_valid=0 cycles → state and step count unchanged; a start at step 7 → v_mem=0, spike_count=0, busy=1, and a full 16 further samples are needed for done.
- Reset mid-window: rst_n=0 for one cycle at step 5 → next cycle spike, spike_count, v_mem, busy and done are all 0 and the state is IDLE; sum_valid is ignored until start.
- Collision: start and sum_valid high in the same cycle with sum_in=2000 → no spike; v_mem=0 and step count 0 after that edge.
